s_axis_cc_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single completer-completion (CC) AXI-Stream input of the UltraScale PCIe PHY adapter between two completion sources, e.g. the MMIO completer and the DMA/MSI-X table completer. It sits directly upstream of the CC adapter, in the `user_clk` domain. A grant is held for a whole TLP, from the first beat through the `tlast` beat, so completions are never interleaved. The block also keeps per-port completed-packet counters for debug CSRs.

---
 rtl/s_axis_cc_arbiter.sv | 142 ++++++++++++++
 tb/tb_s_axis_cc_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axis_cc_arbiter.sv
// Packet-granular round-robin arbiter merging two completer-completion AXI-Stream
// sources onto the single CC input of the PCIe adapter, with per-port TLP counters.
module s_axis_cc_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  user_clk,
  input  logic                  user_reset,

  input  logic [DATA_WIDTH-1:0] s0_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_cc_tkeep,
  input  logic                  s0_axis_cc_tlast,
  input  logic [3:0]            s0_axis_cc_tuser,
  input  logic                  s0_axis_cc_tvalid,
  output logic                  s0_axis_cc_tready,

  input  logic [DATA_WIDTH-1:0] s1_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_cc_tkeep,
  input  logic                  s1_axis_cc_tlast,
  input  logic [3:0]            s1_axis_cc_tuser,
  input  logic                  s1_axis_cc_tvalid,
  output logic                  s1_axis_cc_tready,

  output logic [DATA_WIDTH-1:0] m_axis_cc_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_cc_tkeep,
  output logic                  m_axis_cc_tlast,
  output logic [3:0]            m_axis_cc_tuser,
  output logic                  m_axis_cc_tvalid,
  input  logic                  m_axis_cc_tready,

  output logic [1:0]            grant,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [15:0] pkt_cnt1_q, pkt_cnt1_d;

  logic        xfer0, xfer1;

  assign xfer0 = (state_q == GNT0) && s0_axis_cc_tvalid && m_axis_cc_tready;
  assign xfer1 = (state_q == GNT1) && s1_axis_cc_tvalid && m_axis_cc_tready;

  // last resets to 1 so that port 0 wins the first tie after reset.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      pkt_cnt0_q <= 16'd0;
      pkt_cnt1_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    case (state_q)
      IDLE: begin
        if (s0_axis_cc_tvalid && s1_axis_cc_tvalid) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (s0_axis_cc_tvalid) begin
          state_d = GNT0;
        end else if (s1_axis_cc_tvalid) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (xfer0 && s0_axis_cc_tlast) begin
          state_d = IDLE;
          last_d  = 1'b0;
          if (pkt_cnt0_q != CNT_MAX) begin
            pkt_cnt0_d = pkt_cnt0_q + 16'd1;
          end
        end
      end
      GNT1: begin
        if (xfer1 && s1_axis_cc_tlast) begin
          state_d = IDLE;
          last_d  = 1'b1;
          if (pkt_cnt1_q != CNT_MAX) begin
            pkt_cnt1_d = pkt_cnt1_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The datapath is a pure mux on the registered owner, so it adds no latency.
  always_comb begin
    m_axis_cc_tdata   = '0;
    m_axis_cc_tkeep   = '0;
    m_axis_cc_tlast   = 1'b0;
    m_axis_cc_tuser   = 4'd0;
    m_axis_cc_tvalid  = 1'b0;
    s0_axis_cc_tready = 1'b0;
    s1_axis_cc_tready = 1'b0;
    grant             = 2'b00;
    case (state_q)
      GNT0: begin
        m_axis_cc_tdata   = s0_axis_cc_tdata;
        m_axis_cc_tkeep   = s0_axis_cc_tkeep;
        m_axis_cc_tlast   = s0_axis_cc_tlast;
        m_axis_cc_tuser   = s0_axis_cc_tuser;
        m_axis_cc_tvalid  = s0_axis_cc_tvalid;
        s0_axis_cc_tready = m_axis_cc_tready;
        grant             = 2'b01;
      end
      GNT1: begin
        m_axis_cc_tdata   = s1_axis_cc_tdata;
        m_axis_cc_tkeep   = s1_axis_cc_tkeep;
        m_axis_cc_tlast   = s1_axis_cc_tlast;
        m_axis_cc_tuser   = s1_axis_cc_tuser;
        m_axis_cc_tvalid  = s1_axis_cc_tvalid;
        s1_axis_cc_tready = m_axis_cc_tready;
        grant             = 2'b10;
      end
      default: ;
    endcase
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule

// File: tb/tb_s_axis_cc_arbiter.sv
// Bench for s_axis_cc_arbiter: directed vector table, hand-written corner sequences
// and a randomized phase, all checked against an owner/last/count reference model.
module tb_s_axis_cc_arbiter;

  logic         clk;
  logic         rst;
  logic         mReady;
  logic         sValid [2];
  logic         sLast  [2];
  logic [255:0] sData  [2];
  logic [31:0]  sKeep  [2];
  logic [3:0]   sUser  [2];

  logic [255:0] mData;
  logic [31:0]  mKeep;
  logic         mLast, mValid;
  logic [3:0]   mUser;
  logic         s0Ready, s1Ready;
  logic [1:0]   grant;
  logic [15:0]  cnt0, cnt1;

  int assertions = 0;
  int failures   = 0;

  // Reference model: owner is -1 when nobody holds the bus.
  int mOwner;
  int mLastServed;
  int mCnt [2];

  s_axis_cc_arbiter dut (
    .user_clk          (clk),
    .user_reset        (rst),
    .s0_axis_cc_tdata  (sData[0]),
    .s0_axis_cc_tkeep  (sKeep[0]),
    .s0_axis_cc_tlast  (sLast[0]),
    .s0_axis_cc_tuser  (sUser[0]),
    .s0_axis_cc_tvalid (sValid[0]),
    .s0_axis_cc_tready (s0Ready),
    .s1_axis_cc_tdata  (sData[1]),
    .s1_axis_cc_tkeep  (sKeep[1]),
    .s1_axis_cc_tlast  (sLast[1]),
    .s1_axis_cc_tuser  (sUser[1]),
    .s1_axis_cc_tvalid (sValid[1]),
    .s1_axis_cc_tready (s1Ready),
    .m_axis_cc_tdata   (mData),
    .m_axis_cc_tkeep   (mKeep),
    .m_axis_cc_tlast   (mLast),
    .m_axis_cc_tuser   (mUser),
    .m_axis_cc_tvalid  (mValid),
    .m_axis_cc_tready  (mReady),
    .grant             (grant),
    .pkt_cnt0          (cnt0),
    .pkt_cnt1          (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, v0, l0, v1, l1, mr;
    logic [1:0]  grant;
    logic        mv, r0, r1;
    logic [15:0] c0, c1;
  } vec_t;

  vec_t tbl [21];

  task automatic compare(input string name, input logic [255:0] got, input logic [255:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic randData();
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 8; w++) sData[p][w*32 +: 32] = $urandom;
      sKeep[p] = $urandom;
      sUser[p] = 4'($urandom);
    end
  endtask

  task automatic modelReset();
    mOwner      = -1;
    mLastServed = 1;
    mCnt[0]     = 0;
    mCnt[1]     = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic modelStep();
    if (rst) begin
      modelReset();
    end else if (mOwner < 0) begin
      if (sValid[0] && sValid[1]) mOwner = 1 - mLastServed;
      else if (sValid[0])         mOwner = 0;
      else if (sValid[1])         mOwner = 1;
    end else if (sValid[mOwner] && mReady && sLast[mOwner]) begin
      if (mCnt[mOwner] < 65535) mCnt[mOwner] = mCnt[mOwner] + 1;
      mLastServed = mOwner;
      mOwner      = -1;
    end
  endtask

  task automatic checkOutput();
    logic [1:0]   eGrant;
    logic         eValid, eLast;
    logic [255:0] eData;
    logic [31:0]  eKeep;
    logic [3:0]   eUser;
    eGrant = 2'b00; eValid = 1'b0; eLast = 1'b0;
    eData  = '0;    eKeep  = '0;   eUser = '0;
    if (mOwner >= 0) begin
      eGrant = (mOwner == 0) ? 2'b01 : 2'b10;
      eValid = sValid[mOwner];
      eLast  = sLast[mOwner];
      eData  = sData[mOwner];
      eKeep  = sKeep[mOwner];
      eUser  = sUser[mOwner];
    end
    compare("grant",  256'(grant), 256'(eGrant));
    compare("mValid", 256'(mValid), 256'(eValid));
    compare("mData",  mData, eData);
    compare("mKeep",  256'(mKeep), 256'(eKeep));
    compare("mLast",  256'(mLast), 256'(eLast));
    compare("mUser",  256'(mUser), 256'(eUser));
    compare("s0Ready", 256'(s0Ready), 256'((mOwner == 0) && mReady));
    compare("s1Ready", 256'(s1Ready), 256'((mOwner == 1) && mReady));
    compare("cnt0",   256'(cnt0), 256'(mCnt[0]));
    compare("cnt1",   256'(cnt1), 256'(mCnt[1]));
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are checked 1 unit later.
  task automatic applyStimulus();
    #1;
    checkOutput();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic r, input logic v0, input logic l0,
                       input logic v1, input logic l1, input logic mr);
    rst = r; sValid[0] = v0; sLast[0] = l0; sValid[1] = v1; sLast[1] = l1; mReady = mr;
    randData();
  endtask

  task automatic doReset();
    setIn(1, 0, 0, 0, 0, 1);
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
  endtask

  initial begin
    int beats;
    logic [1:0] expG;
    logic mrPat [8];

    tbl[0]  = '{1,1,0,0,0,1, 2'b00,0,0,0, 16'd0,16'd0};
    tbl[1]  = '{0,1,0,0,0,1, 2'b00,0,0,0, 16'd0,16'd0};
    tbl[2]  = '{0,1,0,0,0,1, 2'b01,1,1,0, 16'd0,16'd0};
    tbl[3]  = '{0,1,0,0,0,1, 2'b01,1,1,0, 16'd0,16'd0};
    tbl[4]  = '{0,1,1,0,0,1, 2'b01,1,1,0, 16'd0,16'd0};
    tbl[5]  = '{0,0,0,0,0,1, 2'b00,0,0,0, 16'd1,16'd0};
    tbl[6]  = '{0,1,1,0,0,0, 2'b00,0,0,0, 16'd1,16'd0};
    tbl[7]  = '{0,1,1,0,0,0, 2'b01,1,0,0, 16'd1,16'd0};
    tbl[8]  = '{0,1,1,0,0,0, 2'b01,1,0,0, 16'd1,16'd0};
    tbl[9]  = '{0,1,1,0,0,0, 2'b01,1,0,0, 16'd1,16'd0};
    tbl[10] = '{0,1,1,0,0,0, 2'b01,1,0,0, 16'd1,16'd0};
    tbl[11] = '{0,1,1,0,0,0, 2'b01,1,0,0, 16'd1,16'd0};
    tbl[12] = '{0,1,1,0,0,1, 2'b01,1,1,0, 16'd1,16'd0};
    tbl[13] = '{0,0,0,1,0,1, 2'b00,0,0,0, 16'd2,16'd0};
    tbl[14] = '{0,0,0,1,0,1, 2'b10,1,0,1, 16'd2,16'd0};
    tbl[15] = '{1,0,0,1,0,1, 2'b10,1,0,1, 16'd2,16'd0};
    tbl[16] = '{0,1,1,1,1,1, 2'b00,0,0,0, 16'd0,16'd0};
    tbl[17] = '{0,1,1,1,1,1, 2'b01,1,1,0, 16'd0,16'd0};
    tbl[18] = '{0,1,1,1,1,1, 2'b00,0,0,0, 16'd1,16'd0};
    tbl[19] = '{0,1,1,1,1,1, 2'b10,1,0,1, 16'd1,16'd0};
    tbl[20] = '{0,0,0,0,0,1, 2'b00,0,0,0, 16'd1,16'd1};

    setIn(1, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    modelReset();

    $display("[TB] directed vector table");
    for (int i = 0; i < 21; i++) begin
      setIn(tbl[i].rst, tbl[i].v0, tbl[i].l0, tbl[i].v1, tbl[i].l1, tbl[i].mr);
      #1;
      compare($sformatf("tbl%0d_grant", i), 256'(grant), 256'(tbl[i].grant));
      compare($sformatf("tbl%0d_mvalid", i), 256'(mValid), 256'(tbl[i].mv));
      compare($sformatf("tbl%0d_r0", i), 256'(s0Ready), 256'(tbl[i].r0));
      compare($sformatf("tbl%0d_r1", i), 256'(s1Ready), 256'(tbl[i].r1));
      compare($sformatf("tbl%0d_cnt0", i), 256'(cnt0), 256'(tbl[i].c0));
      compare($sformatf("tbl%0d_cnt1", i), 256'(cnt1), 256'(tbl[i].c1));
      checkOutput();
      modelStep();
      @(posedge clk);
      #1;
    end

    $display("[TB] alternating single-beat packets");
    doReset();
    for (int i = 0; i < 16; i++) begin
      setIn(0, 1, 1, 1, 1, 1);
      expG = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
      #1;
      compare($sformatf("alt%0d_grant", i), 256'(grant), 256'(expG));
      applyStimulus();
    end
    compare("alt_cnt0", 256'(cnt0), 256'(16'd4));
    compare("alt_cnt1", 256'(cnt1), 256'(16'd4));

    $display("[TB] stalled 4-beat s1 packet");
    doReset();
    mrPat = '{1, 0, 0, 1, 1, 0, 1, 1};
    setIn(0, 0, 0, 1, 0, 1);
    applyStimulus();
    beats = 0;
    for (int j = 0; j < 30 && beats < 4; j++) begin
      setIn(0, 1'($urandom), 1'($urandom), !(j == 4 || j == 5), beats == 3, mrPat[j % 8]);
      #1;
      compare($sformatf("stall%0d_grant", j), 256'(grant), 256'(2'b10));
      compare($sformatf("stall%0d_r0", j), 256'(s0Ready), 256'(1'b0));
      applyStimulus();
      if (sValid[1] && mReady) beats++;
    end
    compare("stall_beats", 256'(beats), 256'(4));
    setIn(0, 0, 0, 0, 0, 1);
    #1;
    compare("stall_release", 256'(grant), 256'(2'b00));
    compare("stall_cnt1", 256'(cnt1), 256'(16'd1));
    applyStimulus();

    $display("[TB] counter saturation");
    doReset();
    force dut.pkt_cnt0_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt0_q;
    mCnt[0] = 65534;
    for (int i = 0; i < 6; i++) begin
      setIn(0, 1, 1, 0, 0, 1);
      applyStimulus();
      if (i == 1) compare("sat_first", 256'(cnt0), 256'(16'hFFFF));
    end
    compare("sat_final", 256'(cnt0), 256'(16'hFFFF));

    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 3000; i++) begin
      setIn(($urandom % 64) == 0, 1'($urandom), ($urandom % 3) == 0,
            1'($urandom), ($urandom % 3) == 0, ($urandom % 4) != 0);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
